// File: rtl/booth_mult_arbiter.sv
// ---------------------------------------------------------------------------
// booth_mult_arbiter
//
// Shares one 8x8 signed Booth multiplier core among NREQ requesters.
// A round-robin arbiter accepts one operand pair at a time. A small FSM
// clears the core, loads it and waits out its ITER iteration cycles. It
// then captures the product and returns it tagged with the requester index.
//
// Ports
//   i_clk, i_reset          clock; synchronous active-high reset
//   i_req_valid[NREQ]       requester i has operands
//   o_req_ready[NREQ]       one-hot accept strobe (only in IDLE)
//   i_req_multiplier        slice i = multiplier of requester i
//   i_req_multiplicand      slice i = multiplicand of requester i
//   o_resp_valid            product available (state RESP)
//   i_resp_ready            consumer accepts product
//   o_resp_id               index of the requester owning o_resp_result
//   o_resp_result           signed product, 2*WIDTH bits
//   o_busy                  high in every state except IDLE
//   o_mult_reset            clear strobe to the core (also high during reset)
//   o_mult_load             load strobe to the core
//   o_mult_multiplier       operand to the core
//   o_mult_multiplicand     operand to the core
//   i_mult_result           product from the core
//   o_state                 FSM state, for debug and checkers
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Ready never depends on the transfer itself, and the response
// payload stays stable while o_resp_valid is high and i_resp_ready is low.
// ---------------------------------------------------------------------------
module booth_mult_arbiter #(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 8,
    parameter  int ITER  = 8,
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW    = $clog2(ITER + 1)
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [NREQ-1:0]         i_req_valid,
    output logic [NREQ-1:0]         o_req_ready,
    input  logic [NREQ*WIDTH-1:0]   i_req_multiplier,
    input  logic [NREQ*WIDTH-1:0]   i_req_multiplicand,
    output logic                    o_resp_valid,
    input  logic                    i_resp_ready,
    output logic [IDW-1:0]          o_resp_id,
    output logic [2*WIDTH-1:0]      o_resp_result,
    output logic                    o_busy,
    output logic                    o_mult_reset,
    output logic                    o_mult_load,
    output logic [WIDTH-1:0]        o_mult_multiplier,
    output logic [WIDTH-1:0]        o_mult_multiplicand,
    input  logic [2*WIDTH-1:0]      i_mult_result,
    output logic [2:0]              o_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_LOAD = 3'd2,
        S_RUN  = 3'd3,
        S_CAPT = 3'd4,
        S_RESP = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [IDW-1:0]      r_ptr;
    logic [CW-1:0]       r_cnt;
    logic [WIDTH-1:0]    r_mplier;
    logic [WIDTH-1:0]    r_mcand;
    logic [IDW-1:0]      r_id;
    logic [2*WIDTH-1:0]  r_result;

    logic [NREQ-1:0]     w_grant;
    logic [IDW-1:0]      w_grant_idx;
    logic                w_found;
    logic                w_accept;
    logic                w_ops_active;

    // Position k of the round-robin scan starting at base, wrapped mod NREQ.
    function automatic int rr_index(input int base, input int k);
        int s;
        s = base + k;
        if (s >= NREQ) s = s - NREQ;
        return s;
    endfunction

    // First valid requester at or after the pointer wins.
    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        w_found     = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && i_req_valid[rr_index(int'(r_ptr), k)]) begin
                w_found     = 1'b1;
                w_grant_idx = IDW'(rr_index(int'(r_ptr), k));
            end
        end
        if (w_found) w_grant[w_grant_idx] = 1'b1;
    end

    assign w_accept = (r_state == S_IDLE) && w_found && !i_reset;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_CLR;
            S_CLR:  w_next = S_LOAD;
            S_LOAD: w_next = S_RUN;
            // The counter holds ITER on the first RUN cycle, so leaving at 1
            // gives exactly ITER cycles in RUN.
            S_RUN:  if (r_cnt == CW'(1)) w_next = S_CAPT;
            S_CAPT: w_next = S_RESP;
            S_RESP: if (i_resp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: operand/id latch, pointer, iteration counter, result capture
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_mplier <= '0;
            r_mcand  <= '0;
            r_id     <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_mplier <= i_req_multiplier[w_grant_idx*WIDTH +: WIDTH];
                r_mcand  <= i_req_multiplicand[w_grant_idx*WIDTH +: WIDTH];
                r_id     <= w_grant_idx;
                r_ptr    <= (w_grant_idx == IDW'(NREQ - 1)) ? '0 : w_grant_idx + IDW'(1);
            end
            if (r_state == S_LOAD)     r_cnt <= CW'(ITER);
            else if (r_state == S_RUN) r_cnt <= r_cnt - CW'(1);
            if (r_state == S_CAPT)     r_result <= i_mult_result;
        end
    end

    assign w_ops_active = (r_state == S_CLR) || (r_state == S_LOAD) ||
                          (r_state == S_RUN) || (r_state == S_CAPT);

    assign o_req_ready         = ((r_state == S_IDLE) && !i_reset) ? w_grant : '0;
    assign o_resp_valid        = (r_state == S_RESP);
    assign o_resp_id           = r_id;
    assign o_resp_result       = r_result;
    assign o_busy              = (r_state != S_IDLE);
    assign o_mult_reset        = i_reset || (r_state == S_CLR);
    assign o_mult_load         = (r_state == S_LOAD);
    assign o_mult_multiplier   = w_ops_active ? r_mplier : '0;
    assign o_mult_multiplicand = w_ops_active ? r_mcand  : '0;
    assign o_state             = r_state;

endmodule
